// File: rtl/fpu_add_arbiter.sv
// Round-robin arbiter that shares one FPU adder among N_REQ requesters.
// One operation in flight at a time; a watchdog aborts a stalled adder with a timeout status.
module fpu_add_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_op_a,
    input  logic [32*N_REQ-1:0]   req_op_b,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [3:0]            rsp_status,
    output logic                  fpu_start,
    output logic [31:0]           fpu_op_a,
    output logic [31:0]           fpu_op_b,
    input  logic                  fpu_done,
    input  logic [31:0]           fpu_result,
    input  logic [3:0]            fpu_status,
    output logic                  busy
);

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned PW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [N_REQ-1:0] ONE_HOT0   = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0]    ST_TIMEOUT = 4'b1000;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    grant_q, grant_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    op_a_q, op_a_d;
    logic [DW-1:0]    op_b_q, op_b_d;
    logic             start_q, start_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]    rsp_data_q, rsp_data_d;
    logic [SW-1:0]    rsp_status_q, rsp_status_d;
    logic             busy_q, busy_d;

    logic             win_found;
    logic [PW-1:0]    win_idx;
    logic [PW:0]      cand;
    logic [DW-1:0]    sel_a;
    logic [DW-1:0]    sel_b;

    // Rotating priority search starting just after the last granted requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(N_REQ)) begin
                cand = cand - (PW+1)'(N_REQ);
            end
            if (!win_found && req_valid[cand[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PW-1:0];
            end
        end
    end

    // Operand mux for the current winner.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win_idx == PW'(i)) begin
                sel_a = req_op_a[i*DW +: DW];
                sel_b = req_op_b[i*DW +: DW];
            end
        end
    end

    assign req_ready = (state_q == IDLE && win_found) ? (ONE_HOT0 << win_idx) : '0;

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        start_d      = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    op_a_d  = sel_a;
                    op_b_d  = sel_b;
                    grant_d = win_idx;
                    start_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // Adder completion takes priority over a coincident timeout.
                if (fpu_done) begin
                    rsp_data_d   = fpu_result;
                    rsp_status_d = fpu_status;
                    rsp_valid_d  = ONE_HOT0 << grant_q;
                    state_d      = RESP;
                end else if (cnt_d == CW'(TIMEOUT - 1)) begin
                    rsp_data_d   = '0;
                    rsp_status_d = ST_TIMEOUT;
                    rsp_valid_d  = ONE_HOT0 << grant_q;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[grant_q]) begin
                    rsp_valid_d = '0;
                    ptr_d       = grant_q;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q        <= PW'(N_REQ - 1);
            grant_q      <= '0;
            cnt_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            start_q      <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            start_q      <= start_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            busy_q       <= busy_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_status = rsp_status_q;
    assign fpu_start  = start_q;
    assign fpu_op_a   = op_a_q;
    assign fpu_op_b   = op_b_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Directed bench for fpu_add_arbiter: single op, round-robin, timeout, back-pressure,
// reset mid-operation and stray adder completions.
module tb_fpu_add_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned TO = 64;

    logic              clock = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [32*NR-1:0]  req_op_a;
    logic [32*NR-1:0]  req_op_b;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_ready;
    logic [31:0]       rsp_data;
    logic [3:0]        rsp_status;
    logic              fpu_start;
    logic [31:0]       fpu_op_a;
    logic [31:0]       fpu_op_b;
    logic              fpu_done;
    logic [31:0]       fpu_result;
    logic [3:0]        fpu_status;
    logic              busy;

    logic [31:0] exp_a [NR];
    logic [31:0] exp_b [NR];

    int total = 0;
    int bad   = 0;

    fpu_add_arbiter #(.N_REQ(NR), .TIMEOUT(TO)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op_a   (req_op_a),
        .req_op_b   (req_op_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_status (rsp_status),
        .fpu_start  (fpu_start),
        .fpu_op_a   (fpu_op_a),
        .fpu_op_b   (fpu_op_b),
        .fpu_done   (fpu_done),
        .fpu_result (fpu_result),
        .fpu_status (fpu_status),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    always_comb begin
        req_op_a = '0;
        req_op_b = '0;
        for (int i = 0; i < NR; i++) begin
            req_op_a[32*i +: 32] = exp_a[i];
            req_op_b[32*i +: 32] = exp_b[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_req_ready"},  32'(req_ready),  32'h0);
        chk({tag, "_rsp_valid"},  32'(rsp_valid),  32'h0);
        chk({tag, "_rsp_data"},   rsp_data,        32'h0);
        chk({tag, "_rsp_status"}, 32'(rsp_status), 32'h0);
        chk({tag, "_fpu_start"},  32'(fpu_start),  32'h0);
        chk({tag, "_fpu_op_a"},   fpu_op_a,        32'h0);
        chk({tag, "_fpu_op_b"},   fpu_op_b,        32'h0);
        chk({tag, "_busy"},       32'(busy),       32'h0);
    endtask

    // One full operation for requester g; adder answers dly cycles after fpu_start.
    // Caller holds req_valid and a high rsp_ready[g].
    task automatic do_op(input int g, input int dly, input logic [31:0] res, input logic [3:0] st);
        #1;
        chk("op_grant", 32'(req_ready), 32'(1) << g);
        tick();
        chk("op_start", 32'(fpu_start), 32'h1);
        chk("op_a", fpu_op_a, exp_a[g]);
        chk("op_b", fpu_op_b, exp_b[g]);
        chk("op_ready_busy", 32'(req_ready), 32'h0);
        repeat (dly) tick();
        fpu_done   = 1'b1;
        fpu_result = res;
        fpu_status = st;
        tick();
        fpu_done = 1'b0;
        chk("op_rsp_valid", 32'(rsp_valid), 32'(1) << g);
        chk("op_rsp_data", rsp_data, res);
        chk("op_rsp_status", 32'(rsp_status), 32'(st));
        tick();
        chk("op_rsp_clear", 32'(rsp_valid), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset      = 1'b0;
        req_valid  = '0;
        rsp_ready  = '0;
        fpu_done   = 1'b0;
        fpu_result = '0;
        fpu_status = '0;
        exp_a[0]   = 32'h3E00_0000;
        exp_b[0]   = 32'h3E00_0000;
        for (int i = 1; i < NR; i++) begin
            exp_a[i] = 32'hA000_0000 + 32'(i);
            exp_b[i] = 32'hB000_0000 + 32'(i);
        end

        repeat (2) @(posedge clock);
        #2;
        chk_idle_zero("reset");
        reset = 1'b1;
        tick();

        // Single operation from requester 0, adder answers 3 cycles after start.
        req_valid = 4'b0001;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("t1_start", 32'(fpu_start), 32'h1);
        chk("t1_op_a", fpu_op_a, 32'h3E00_0000);
        chk("t1_op_b", fpu_op_b, 32'h3E00_0000);
        chk("t1_busy", 32'(busy), 32'h1);
        tick();
        chk("t1_start_pulse", 32'(fpu_start), 32'h0);
        tick();
        tick();
        fpu_done   = 1'b1;
        fpu_result = 32'h4000_0000;
        fpu_status = 4'h0;
        #1;
        chk("t1_no_early_rsp", 32'(rsp_valid), 32'h0);
        tick();
        fpu_done = 1'b0;
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1_rsp_data", rsp_data, 32'h4000_0000);
        chk("t1_rsp_status", 32'(rsp_status), 32'h0);

        // Stray completion while holding the response.
        fpu_done   = 1'b1;
        fpu_result = 32'hDEAD_BEEF;
        fpu_status = 4'hF;
        tick();
        fpu_done = 1'b0;
        chk("stray_resp_valid", 32'(rsp_valid), 32'h1);
        chk("stray_resp_data", rsp_data, 32'h4000_0000);
        chk("stray_resp_status", 32'(rsp_status), 32'h0);
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = '0;
        chk("t1_rsp_clear", 32'(rsp_valid), 32'h0);
        chk("t1_idle_busy", 32'(busy), 32'h0);

        // Stray completion while idle.
        fpu_done   = 1'b1;
        fpu_result = 32'h1234_5678;
        fpu_status = 4'h7;
        tick();
        fpu_done = 1'b0;
        chk("stray_idle_busy", 32'(busy), 32'h0);
        chk("stray_idle_valid", 32'(rsp_valid), 32'h0);
        chk("stray_idle_data", rsp_data, 32'h4000_0000);
        chk("stray_idle_start", 32'(fpu_start), 32'h0);
        chk("stray_idle_op_a", fpu_op_a, 32'h3E00_0000);

        // Round-robin from a fresh pointer: 0,1,2,3,0.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        do_op(0, 3, 32'h1000_0000, 4'h1);
        do_op(1, 1, 32'h1000_0001, 4'h2);
        do_op(2, 2, 32'h1000_0002, 4'h0);
        do_op(3, 4, 32'h1000_0003, 4'h4);
        do_op(0, 1, 32'h1000_0004, 4'h0);
        req_valid = '0;

        // Timeout on requester 1: response exactly TO cycles after start.
        req_valid = 4'b0010;
        #1;
        chk("to_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        chk("to_start", 32'(fpu_start), 32'h1);
        repeat (TO - 1) tick();
        chk("to_not_yet", 32'(rsp_valid), 32'h0);
        tick();
        chk("to_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("to_rsp_data", rsp_data, 32'h0);
        chk("to_rsp_status", 32'(rsp_status), 32'h8);
        tick();
        chk("to_rsp_clear", 32'(rsp_valid), 32'h0);

        // Back-pressure on requester 2 with 0 and 1 pending.
        rsp_ready = '0;
        req_valid = 4'b0100;
        #1;
        chk("bp_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0011;
        #1;
        chk("bp_start", 32'(fpu_start), 32'h1);
        chk("bp_ready_blocked", 32'(req_ready), 32'h0);
        repeat (2) tick();
        fpu_done   = 1'b1;
        fpu_result = 32'hC0A0_0000;
        fpu_status = 4'h3;
        tick();
        fpu_done  = 1'b0;
        rsp_ready = 4'b1011;
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_valid", 32'(rsp_valid), 32'h4);
            chk("bp_hold_data", rsp_data, 32'hC0A0_0000);
            chk("bp_hold_status", 32'(rsp_status), 32'h3);
            chk("bp_hold_ready", 32'(req_ready), 32'h0);
            tick();
        end
        rsp_ready = 4'b0100;
        #1;
        chk("bp_last_valid", 32'(rsp_valid), 32'h4);
        tick();
        rsp_ready = '0;
        chk("bp_rsp_clear", 32'(rsp_valid), 32'h0);
        chk("bp_next_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("bp_next_start", 32'(fpu_start), 32'h1);
        chk("bp_next_op_a", fpu_op_a, exp_a[0]);

        // Reset two cycles after start, then a late completion.
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk_idle_zero("rst_wait");
        tick();
        reset      = 1'b1;
        fpu_done   = 1'b1;
        fpu_result = 32'h5555_5555;
        fpu_status = 4'h2;
        tick();
        fpu_done = 1'b0;
        chk("late_done_busy", 32'(busy), 32'h0);
        chk("late_done_valid", 32'(rsp_valid), 32'h0);
        chk("late_done_data", rsp_data, 32'h0);
        chk("late_done_start", 32'(fpu_start), 32'h0);
        rsp_ready = 4'b0010;
        req_valid = 4'b0010;
        do_op(1, 2, 32'h4080_0000, 4'h0);
        req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_add_arbiter.md
Name: fpu_add_arbiter

Overview:
- Shares one FPU adder (1-bit sign, 6-bit exponent with bias 31, 25-bit mantissa) among N_REQ requesters.
- Round-robin arbitration; operands are latched and issued with a one-cycle start pulse.
- Waits for adder completion, guarded by a watchdog.
- Returns the result and status to the granted requester over a valid/ready response handshake; one operation in flight at a time.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT, 64, max cycles waited for fpu_done before aborting (>=2)

Ports:
clock  input  1  system clock
reset  input  1  async active-low reset
req_valid  input  N_REQ  request pending, one bit per requester
req_ready  output  N_REQ  one-hot accept; transfer when req_valid[i]&req_ready[i]
req_op_a  input  32*N_REQ  operand A, requester i at [32*i+31:32*i]
req_op_b  input  32*N_REQ  operand B, same packing
rsp_valid  output  N_REQ  one-hot response valid
rsp_ready  input  N_REQ  requester accepts response
rsp_data  output  32  result for the requester flagged in rsp_valid
rsp_status  output  4  status for the requester flagged in rsp_valid
fpu_start  output  1  one-cycle start pulse to the adder
fpu_op_a  output  32  registered operand A to the adder
fpu_op_b  output  32  registered operand B to the adder
fpu_done  input  1  adder result valid (single-cycle pulse)
fpu_result  input  32  adder result, sampled when fpu_done=1
fpu_status  input  4  adder status, sampled when fpu_done=1
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock/reset: clock clock; reset reset, asynchronous, active-low.
- Reset values:
  - All registered outputs are 0: req_ready, rsp_valid, rsp_data, rsp_status, fpu_start, fpu_op_a, fpu_op_b, busy.
  - State = IDLE; watchdog counter = 0.
  - Last-grant pointer = N_REQ-1, so requester 0 wins first.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching from pointer+1 upward with wrap modulo N_REQ.
  - req_ready is combinational and one-hot on the winner; all zeros if there are no requests.
  - On transfer, in the same edge: latch the winner's operands into fpu_op_a/fpu_op_b, record the grant index, go to ISSUE.
- ISSUE:
  - fpu_start=1 for exactly this one cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - Watchdog counter increments each cycle.
  - fpu_done=1: latch fpu_result into rsp_data and fpu_status into rsp_status; go to RESP.
  - Else, counter reaches TIMEOUT-1: rsp_data=0, rsp_status=4'b1000 (timeout); go to RESP.
  - fpu_done and timeout in the same cycle: fpu_done wins.
- RESP:
  - rsp_valid[grant]=1 (registered), held stable with rsp_data/rsp_status until rsp_ready[grant]=1.
  - On that edge: rsp_valid clears, pointer = grant index, go to IDLE.
  - rsp_ready on non-granted bits is ignored.
- Latency:
  - Accept edge at cycle 0; fpu_start high during cycle 1.
  - fpu_done at cycle k gives rsp_valid from cycle k+1.
  - A new request can be accepted no earlier than the cycle after the response handshake.
- req_ready is 0 in every state except IDLE; requests arriving meanwhile stay pending (requesters hold req_valid and operands).
- fpu_done outside WAIT is ignored; no state or data change.
- fpu_op_a/fpu_op_b hold their value until the next accept.
- The block does no arithmetic on operands; data passes through unmodified.
- Reset asserted mid-operation:
  - Immediate return to reset values; in-flight operation dropped, no response.
  - Pointer reinitialised.
  - A late fpu_done after reset release is ignored (state IDLE).
- A requester dropping req_valid before grant is legal. The winner is re-evaluated every IDLE cycle.

Test Plan:
- Single op: requester 0, A=0x3E000000 (1.0), B=0x3E000000, adder model returns 0x40000000 (2.0) status 0 three cycles after fpu_start -> fpu_op_a=0x3E000000 during start; rsp_valid[0] with rsp_data=0x40000000, status 0; accept-to-rsp_valid = 5 cycles.
- Round-robin: req_valid=4'b1111 held, rsp_ready tied high -> grant order 0,1,2,3,0; req_ready always one-hot; never two grants without an intervening response.
- Timeout: adder never asserts fpu_done -> rsp_status=4'b1000, rsp_data=0 exactly TIMEOUT cycles after fpu_start; next request served normally.
- Back-pressure: rsp_ready[2] held low 10 cycles with req_valid=4'b0011 pending -> rsp_valid[2], data and status stable; req_ready=0 throughout; requester 0 granted in the cycle after the handshake (pointer was 2).
- Reset in WAIT: assert reset 2 cycles after fpu_start, then a late fpu_done after release -> all outputs 0, no rsp_valid, busy=0; next request from requester 1 alone is granted.
- Stray done: fpu_done pulse while IDLE and while RESP -> rsp_data and state unchanged.
